// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and helpers for the player-input path
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } btn_state_t;

  localparam int unsigned CLK_HZ = 100_000_000;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot input; lowest set bit wins otherwise.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_event_conditioner_if.sv
// rtl/btn_event_conditioner_if.sv - press-event handshake between conditioner and game FSM
interface btn_event_conditioner_if;
  logic       evt_valid;
  logic [1:0] evt_val;
  logic       evt_ack;
  logic       multi_err;
  logic       overrun;
  logic       held;
  logic [1:0] dbg_state;

  modport master (
    output evt_valid, evt_val, multi_err, overrun, held, dbg_state,
    input  evt_ack
  );

  modport slave (
    input  evt_valid, evt_val, multi_err, overrun, held, dbg_state,
    output evt_ack
  );
endinterface

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchroniser for asynchronous inputs
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_event_conditioner.sv
// rtl/btn_event_conditioner.sv - debounce four buttons and emit one held event per press
module btn_event_conditioner
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     btn_raw,
  btn_event_conditioner_if.master        evt
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_QUALIFY = QUALIFY;
  localparam logic [1:0] ST_PRESSED = PRESSED;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s;
  logic [1:0]       state_d, state_q;
  logic [3:0]       vec_d, vec_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             held_d, held_q;
  logic             multi_err_d, multi_err_q;
  logic             evt_valid_d, evt_valid_q;
  logic [1:0]       evt_val_d, evt_val_q;
  logic             overrun_d, overrun_q;
  logic             issue;

  btn_sync #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    held_d      = held_q;
    multi_err_d = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s != 4'd0) begin
          vec_d   = s;
          cnt_d   = '0;
          state_d = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (s == 4'd0) begin
          state_d = ST_IDLE;
        end else if (s != vec_q) begin
          vec_d = s;
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_PRESSED;
          held_d  = 1'b1;
          if (is_onehot(vec_q)) issue = 1'b1;
          else                  multi_err_d = 1'b1;
        end
      end
      // Non-zero changes while held are deliberately ignored until a full release.
      ST_PRESSED: begin
        if (s == 4'd0) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (s != 4'd0) begin
          cnt_d   = '0;
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A coincident ack frees the slot, so a new issue replaces rather than overruns.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_val_d   = evt_val_q;
    overrun_d   = overrun_q;
    if (issue) begin
      if (!evt_valid_q || evt.evt_ack) begin
        evt_valid_d = 1'b1;
        evt_val_d   = onehot_idx(vec_q);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (evt.evt_ack && evt_valid_q) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      multi_err_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_val_q   <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      multi_err_q <= multi_err_d;
      evt_valid_q <= evt_valid_d;
      evt_val_q   <= evt_val_d;
      overrun_q   <= overrun_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_val   = evt_val_q;
  assign evt.multi_err = multi_err_q;
  assign evt.overrun   = overrun_q;
  assign evt.held      = held_q;
  assign evt.dbg_state = state_q;

endmodule

// File: tb/tb_btn_event_conditioner.sv
// tb/tb_btn_event_conditioner.sv - directed and random checks against a run-length reference model
module tb_btn_event_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  int         n_chk = 0;
  int         n_pass = 0;

  btn_event_conditioner_if evt_if ();

  btn_event_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .evt     (evt_if)
  );

  always #5 clk = ~clk;

  // Reference: a press is accepted once D+1 identical non-zero samples of the
  // synchronised vector are seen while released; a release after D+1 zero samples.
  logic [3:0] m_s1, m_s, m_last;
  int         m_run;
  bit         m_held, m_valid, m_merr, m_ovr;
  logic [1:0] m_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_last = '0; m_run = 0;
    m_held = 0; m_valid = 0; m_merr = 0; m_ovr = 0; m_val = '0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input bit ack);
    logic [3:0] s;
    bit         taken;
    s = m_s;
    if (s == m_last) m_run++;
    else m_run = 1;
    m_last = s;
    m_merr = 0;
    taken  = 0;
    if (!m_held && s != 0 && m_run == D + 1) begin
      m_held = 1;
      if ($countones(s) == 1) begin
        taken = 1;
        if (!m_valid || ack) begin
          m_valid = 1;
          m_val   = idx_of(s);
        end else begin
          m_ovr = 1;
        end
      end else begin
        m_merr = 1;
      end
    end else if (m_held && s == 0 && m_run == D + 1) begin
      m_held = 0;
    end
    if (!taken && ack && m_valid) m_valid = 0;
    m_s  = m_s1;
    m_s1 = raw;
  endtask

  task automatic compare_all();
    check("evt_valid", evt_if.evt_valid, m_valid);
    check("evt_val",   evt_if.evt_val,   m_val);
    check("multi_err", evt_if.multi_err, m_merr);
    check("overrun",   evt_if.overrun,   m_ovr);
    check("held",      evt_if.held,      m_held);
    check("state_held_bit", evt_if.dbg_state[1], m_held);
  endtask

  task automatic cycle(input logic [3:0] raw, input bit ack);
    btn_raw = raw;
    evt_if.evt_ack = ack;
    @(posedge clk);
    if (reset) model_edge(raw, ack);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_outputs();
    check("rst_evt_valid", evt_if.evt_valid, 0);
    check("rst_evt_val",   evt_if.evt_val,   0);
    check("rst_multi_err", evt_if.multi_err, 0);
    check("rst_overrun",   evt_if.overrun,   0);
    check("rst_held",      evt_if.held,      0);
    check("rst_state",     evt_if.dbg_state, 0);
  endtask

  // Asynchronous reset mid-cycle, held low for three cycles with raw kept at 'raw'.
  task automatic pulse_reset(input logic [3:0] raw);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    repeat (3) cycle(raw, 1'b0);
    reset = 1'b1;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    repeat (n) cycle(raw, 1'b0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    btn_raw = '0;
    evt_if.evt_ack = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: clean press, ack, release
    for (int i = 1; i <= 20; i++) begin
      cycle(4'b0100, i == 11);
      if (i == 6) check("t1_not_yet", evt_if.evt_valid, 0);
      if (i == 7) begin
        check("t1_valid", evt_if.evt_valid, 1);
        check("t1_val",   evt_if.evt_val,   2);
        check("t1_held",  evt_if.held,      1);
      end
      if (i == 11) check("t1_acked", evt_if.evt_valid, 0);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b0000, 1'b0);
      if (i == 6) check("t1_still_held", evt_if.held, 1);
      if (i == 7) check("t1_released", evt_if.held, 0);
    end

    // 2: bounce then stable hold
    for (int i = 0; i < 12; i++) cycle(((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
    check("t2_no_bounce_evt", evt_if.evt_valid, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b0100, 1'b0);
      if (i == 6) check("t2_not_yet", evt_if.evt_valid, 0);
      if (i == 7) check("t2_valid", evt_if.evt_valid, 1);
    end
    check("t2_val", evt_if.evt_val, 2);
    cycle(4'b0100, 1'b1);
    hold(4'b0000, 10);

    // 3: multi-button press
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0011, 1'b0);
      if (evt_if.multi_err) pulses++;
    end
    check("t3_multi_pulses", pulses, 1);
    check("t3_no_evt", evt_if.evt_valid, 0);
    check("t3_held", evt_if.held, 1);
    hold(4'b0001, 12);
    check("t3_no_evt_change", evt_if.evt_valid, 0);
    hold(4'b0000, 10);

    // 4: overrun
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    hold(4'b1000, 10);
    hold(4'b0000, 10);
    check("t4_valid", evt_if.evt_valid, 1);
    check("t4_val_kept", evt_if.evt_val, 0);
    check("t4_overrun", evt_if.overrun, 1);
    cycle(4'b0000, 1'b1);
    check("t4_ack_clears", evt_if.evt_valid, 0);
    check("t4_overrun_sticky", evt_if.overrun, 1);

    // 5: ack coincident with a new issue
    pulse_reset(4'b0000);
    hold(4'b1000, 10);
    hold(4'b0000, 10);
    check("t5_pending", evt_if.evt_val, 3);
    for (int i = 1; i <= 7; i++) cycle(4'b0010, i == 7);
    check("t5_valid", evt_if.evt_valid, 1);
    check("t5_val", evt_if.evt_val, 1);
    check("t5_no_overrun", evt_if.overrun, 0);
    hold(4'b0010, 3);
    hold(4'b0000, 10);

    // 6: reset mid-QUALIFY with an event pending and the button still held
    hold(4'b0100, 4);
    check("t6_pending", evt_if.evt_valid, 1);
    pulse_reset(4'b0100);
    for (int i = 1; i <= 9; i++) begin
      cycle(4'b0100, 1'b0);
      if (i == 6) check("t6_not_yet", evt_if.evt_valid, 0);
      if (i == 7) begin
        check("t6_fresh", evt_if.evt_valid, 1);
        check("t6_fresh_val", evt_if.evt_val, 2);
      end
    end
    hold(4'b0000, 10);
    cycle(4'b0000, 1'b1);

    // random segments
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] pat;
      int         r, len;
      r = $urandom_range(0, 9);
      if (r < 2)       pat = 4'b0000;
      else if (r == 2) pat = 4'($urandom_range(1, 15));
      else             pat = 4'b0001 << $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) cycle(pat, $urandom_range(0, 5) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
